data_mem_responder: RTL and testbench

//  Memory-side responder for the core's data-memory port. It accepts one load/store request at a time over
//  a valid/yumi handshake and services it from an internal word-addressed RAM. After a programmable latency
//  it returns a response, held until the core consumes it. It sits between core_flattened's to_mem/from_mem

---
 rtl/data_mem_responder.sv | 115 +++++++++++
 tb/tb_data_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time and answers from an internal word RAM
// after latency_p cycles; the response is held until the core takes it with resp_yumi_i.
module data_mem_responder #(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic        req_wen_i,
  input  logic [3:0]  req_byte_en_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_yumi_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  input  logic        resp_yumi_i,
  output logic        busy_o
);

  localparam int         depth_lp = 1 << addr_width_p;
  localparam logic [3:0] lat_m1_lp = 4'(latency_p - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic                    wen_q;
  logic                    err_q;
  logic [addr_width_p-1:0] idx_q;
  logic                    resp_valid_q;
  logic                    resp_err_q;
  logic [31:0]             resp_data_q;
  logic                    busy_q;

  logic [31:0]             mem_q [depth_lp];

  logic [addr_width_p-1:0] req_idx;
  logic                    req_err;
  logic                    accept;

  assign req_idx = req_addr_i[addr_width_p+1:2];
  assign req_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:addr_width_p+2] != '0);
  assign accept  = (state_q == IDLE) && req_valid_i && !reset;

  assign req_yumi_o   = accept;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign busy_o       = busy_q;

  // RAM is deliberately not reset; stores commit on the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && req_wen_i && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (req_byte_en_i[b]) mem_q[req_idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wen_q        <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            wen_q   <= req_wen_i;
            idx_q   <= req_idx;
            err_q   <= req_err;
            cnt_q   <= lat_m1_lp;
            state_q <= WAIT;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
            if (err_q)      resp_data_q <= 32'hDEAD_BEEF;
            else if (wen_q) resp_data_q <= 32'h0;
            else            resp_data_q <= mem_q[idx_q];
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          // Yumi cycle returns to IDLE only; acceptance waits for the next cycle.
          if (resp_yumi_i) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (latency 2, 1, 15) checked against an associative-array memory model.
module tb_data_mem_responder;

  localparam int AW = 10;
  localparam int LAT [3] = '{2, 1, 15};

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [3];
  logic        req_wen   [3];
  logic [3:0]  req_be    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        req_yumi  [3];
  logic        resp_valid[3];
  logic [31:0] resp_data [3];
  logic        resp_err  [3];
  logic        resp_yumi [3];
  logic        busy      [3];

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;

  data_mem_responder #(.addr_width_p(AW), .latency_p(2)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid_i(req_valid[0]), .req_wen_i(req_wen[0]),
    .req_byte_en_i(req_be[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .req_yumi_o(req_yumi[0]), .resp_valid_o(resp_valid[0]), .resp_data_o(resp_data[0]),
    .resp_err_o(resp_err[0]), .resp_yumi_i(resp_yumi[0]), .busy_o(busy[0]));

  data_mem_responder #(.addr_width_p(AW), .latency_p(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid_i(req_valid[1]), .req_wen_i(req_wen[1]),
    .req_byte_en_i(req_be[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .req_yumi_o(req_yumi[1]), .resp_valid_o(resp_valid[1]), .resp_data_o(resp_data[1]),
    .resp_err_o(resp_err[1]), .resp_yumi_i(resp_yumi[1]), .busy_o(busy[1]));

  data_mem_responder #(.addr_width_p(AW), .latency_p(15)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid_i(req_valid[2]), .req_wen_i(req_wen[2]),
    .req_byte_en_i(req_be[2]), .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]),
    .req_yumi_o(req_yumi[2]), .resp_valid_o(resp_valid[2]), .resp_data_o(resp_data[2]),
    .resp_err_o(resp_err[2]), .resp_yumi_i(resp_yumi[2]), .busy_o(busy[2]));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Drives a request, checks it is taken immediately, and predicts the response from the memory model.
  task automatic issue(input int k, input logic wen, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] ed, output logic ee, output logic kn);
    logic [31:0] word;
    int key;
    ee  = (addr[1:0] != 2'b00) || (addr[31:AW+2] != 0);
    key = k * 4096 + int'(addr[AW+1:2]);
    kn  = 1'b1;
    if (ee)       ed = 32'hDEAD_BEEF;
    else if (wen) ed = 32'h0;
    else if (ref_mem.exists(key)) ed = ref_mem[key];
    else begin
      ed = 32'h0;
      kn = 1'b0;
    end
    @(negedge clk);
    req_valid[k] = 1'b1; req_wen[k] = wen; req_be[k] = be; req_addr[k] = addr; req_wdata[k] = wdata;
    #1;
    check_eq("req_yumi", 32'(req_yumi[k]), 32'd1);
    @(posedge clk);
    if (wen && !ee && be != 4'h0) begin
      if (ref_mem.exists(key) || be == 4'hF) begin
        word = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[key] = word;
      end
    end
    #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic await_resp(input int k, input logic [31:0] ed, input logic ee, input logic kn);
    int cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (resp_valid[k]) break;
      check_eq("busy_wait", 32'(busy[k]), 32'd1);
    end
    check_eq("latency", 32'(cyc), 32'(LAT[k]));
    if (kn) check_eq("resp_data", resp_data[k], ed);
    check_eq("resp_err", 32'(resp_err[k]), 32'(ee));
  endtask

  task automatic consume(input int k, input int hold, input logic [31:0] ed, input logic ee, input logic kn);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(resp_valid[k]), 32'd1);
      if (kn) check_eq("hold_data", resp_data[k], ed);
      check_eq("hold_err", 32'(resp_err[k]), 32'(ee));
      check_eq("hold_req_yumi", 32'(req_yumi[k]), 32'd0);
    end
    resp_yumi[k] = 1'b1;
    #1;
    check_eq("yumi_cyc_req_yumi", 32'(req_yumi[k]), 32'd0);
    @(posedge clk); #1;
    resp_yumi[k] = 1'b0;
    check_eq("done_valid", 32'(resp_valid[k]), 32'd0);
    check_eq("done_data", resp_data[k], 32'd0);
    check_eq("done_err", 32'(resp_err[k]), 32'd0);
    check_eq("done_busy", 32'(busy[k]), 32'd0);
  endtask

  task automatic txn(input int k, input logic wen, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold);
    logic [31:0] ed;
    logic ee, kn;
    issue(k, wen, be, addr, wdata, ed, ee, kn);
    await_resp(k, ed, ee, kn);
    consume(k, hold, ed, ee, kn);
  endtask

  initial begin
    logic [31:0] ed;
    logic ee, kn;
    logic [31:0] addr;
    int k, sel;

    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_wen[i] = 1'b0; req_be[i] = 4'h0;
      req_addr[i] = 32'h0; req_wdata[i] = 32'h0; resp_yumi[i] = 1'b0;
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_valid", 32'(resp_valid[i]), 32'd0);
      check_eq("rst_data", resp_data[i], 32'd0);
      check_eq("rst_err", 32'(resp_err[i]), 32'd0);
      check_eq("rst_busy", 32'(busy[i]), 32'd0);
    end
    req_valid[0] = 1'b1;
    #1;
    check_eq("rst_req_yumi", 32'(req_yumi[0]), 32'd0);
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Store, load, partial store, reload
    txn(0, 1'b1, 4'hF, 32'h10, 32'hA5A5_1234, 0);
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 1);
    txn(0, 1'b1, 4'b0010, 32'h10, 32'h0000_FF00, 0);
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0, ed, ee, kn);
    await_resp(0, ed, ee, kn);
    check_eq("partial_const", resp_data[0], 32'hA5A5_FF34);
    consume(0, 0, ed, ee, kn);

    // Errored accesses, including a store that aliases word 0
    txn(0, 1'b1, 4'hF, 32'h0, 32'h1357_9BDF, 0);
    txn(0, 1'b0, 4'h0, 32'h13, 32'h0, 0);
    txn(0, 1'b0, 4'h0, 32'h0000_1000, 32'h0, 0);
    txn(0, 1'b1, 4'hF, 32'h0000_1000, 32'hFFFF_FFFF, 0);
    txn(0, 1'b1, 4'hF, 32'h2, 32'hFFFF_FFFF, 0);
    txn(0, 1'b0, 4'h0, 32'h0, 32'h0, 0);
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 0);
    // Zero byte-enable store leaves the word alone
    txn(0, 1'b1, 4'h0, 32'h10, 32'h0BAD_0BAD, 0);
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 0);

    // Held response with a pending request, accepted right after the yumi cycle
    issue(0, 1'b0, 4'h0, 32'h0, 32'h0, ed, ee, kn);
    await_resp(0, ed, ee, kn);
    req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_be[0] = 4'h0; req_addr[0] = 32'h10; req_wdata[0] = 32'h0;
    consume(0, 5, ed, ee, kn);
    check_eq("next_cycle_accept", 32'(req_yumi[0]), 32'd1);
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 0);

    // Reset during WAIT of a store: response dropped, store stays committed
    issue(0, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D, ed, ee, kn);
    reset = 1'b1;
    req_valid[0] = 1'b1;
    #1;
    check_eq("mid_rst_valid", 32'(resp_valid[0]), 32'd0);
    check_eq("mid_rst_busy", 32'(busy[0]), 32'd0);
    check_eq("mid_rst_data", resp_data[0], 32'd0);
    check_eq("mid_rst_err", 32'(resp_err[0]), 32'd0);
    check_eq("mid_rst_req_yumi", 32'(req_yumi[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    req_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("post_rst_valid", 32'(resp_valid[0]), 32'd0);
      check_eq("post_rst_busy", 32'(busy[0]), 32'd0);
    end
    txn(0, 1'b0, 4'h0, 32'h20, 32'h0, 0);

    // Latency extremes
    txn(1, 1'b1, 4'hF, 32'h40, 32'h1111_2222, 0);
    txn(1, 1'b0, 4'h0, 32'h40, 32'h0, 1);
    txn(2, 1'b1, 4'hF, 32'h40, 32'h3333_4444, 0);
    txn(2, 1'b0, 4'h0, 32'h40, 32'h0, 2);

    // Randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      k   = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      if (sel == 0)      addr = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else if (sel == 1) addr = $urandom | 32'h0000_1000;
      else               addr = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
      txn(k, 1'($urandom_range(0, 1)), 4'($urandom), addr, $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
